argon_regfile_mp: RTL and testbench

Parametrised multi-port successor to the Argon register file.
- Generalises width, register count and number of read ports.
- Adds two prioritised write ports: ALU writeback (A) and bus latch (B).
- Adds a hardware-flags merge path, a per-register busy scoreboard for the control unit, and sticky error reporting.
- Sits between decode/control, the ALU and the Argon bus adapter.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/argon_regfile_scoreboard.sv | 36 +++
 rtl/argon_regfile_mp.sv | 103 ++++++++++
 tb/tb_argon_regfile_mp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port Argon register file: error bit positions,
// the default hardware-flag width and the register-index width helper.
package regfile_mp_pkg;

   localparam int ERR_COLLIDE  = 0;
   localparam int ERR_RSV_BUSY = 1;

   localparam int FLAG_HW_BITS_DEF = 8;

   // Width of a register index (reg_idx_t) for a given register count.
   function automatic int reg_idx_w(input int num_regs);
      return $clog2(num_regs);
   endfunction

endpackage

// File: rtl/argon_regfile_scoreboard.sv
// Per-register busy scoreboard: a reservation sets a bit, a committed write clears it,
// and a reservation wins over a same-cycle clear. r0 is never busy.
module argon_regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = reg_idx_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rsv_en,
   input  logic [IDX_W-1:0]    rsv_addr,
   input  logic [NUM_REGS-1:0] clr_mask,
   output logic [NUM_REGS-1:0] busy,
   output logic                rsv_busy
);

   logic                rsv_ok;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] keep_mask;

   assign rsv_ok    = rsv_en && (rsv_addr != '0);
   assign keep_mask = {{(NUM_REGS-1){1'b1}}, 1'b0};
   assign rsv_busy  = rsv_ok && busy[rsv_addr];

   always_comb begin
      set_mask = '0;
      if (rsv_ok) set_mask[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= ((busy & ~clr_mask) | set_mask) & keep_mask;
   end

endmodule

// File: rtl/argon_regfile_mp.sv
// Multi-port Argon register file: NUM_RD read ports, prioritised ALU (A) / bus (B) writes,
// hardware flags merge, busy scoreboard and sticky errors. Define ARGON_REGFILE_BYPASS_EN for write-to-read forwarding.
module argon_regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int NUM_REGS     = 8,
   parameter int NUM_RD       = 2,
   parameter int FLAG_IDX     = NUM_REGS - 1,
   parameter int FLAG_HW_BITS = FLAG_HW_BITS_DEF,
   parameter int IDX_W        = reg_idx_w(NUM_REGS)
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic [NUM_RD*IDX_W-1:0]  i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rd_data,
   input  logic                     i_wa_en,
   input  logic [IDX_W-1:0]         i_wa_addr,
   input  logic [DATA_W-1:0]        i_wa_data,
   input  logic                     i_wb_en,
   input  logic [IDX_W-1:0]         i_wb_addr,
   input  logic [DATA_W-1:0]        i_wb_data,
   input  logic                     i_flags_we,
   input  logic [FLAG_HW_BITS-1:0]  i_flags,
   output logic [DATA_W-1:0]        o_flags,
   input  logic                     i_rsv_en,
   input  logic [IDX_W-1:0]         i_rsv_addr,
   output logic [NUM_REGS-1:0]      o_busy,
   output logic                     o_collide,
   output logic [1:0]               o_err,
   input  logic                     i_err_clr
);

   logic [DATA_W-1:0]   regs      [NUM_REGS];
   logic [DATA_W-1:0]   regs_next [NUM_REGS];
   logic [DATA_W-1:0]   rd_src    [NUM_REGS];
   logic [NUM_REGS-1:0] clr_mask;
   logic                wa_ok, wb_ok, collide_now, rsv_busy;

   // B loses to A on the same register; r0 writes are discarded outright.
   assign wa_ok       = i_wa_en && (i_wa_addr != '0);
   assign collide_now = wa_ok && i_wb_en && (i_wb_addr == i_wa_addr);
   assign wb_ok       = i_wb_en && (i_wb_addr != '0) && !collide_now;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_next[i] = regs[i];
         clr_mask[i]  = 1'b0;
         if (i != 0) begin
            if (wb_ok && (i_wb_addr == IDX_W'(i))) begin
               regs_next[i] = i_wb_data;
               clr_mask[i]  = 1'b1;
            end
            if (wa_ok && (i_wa_addr == IDX_W'(i))) begin
               regs_next[i] = i_wa_data;
               clr_mask[i]  = 1'b1;
            end
            if ((i == FLAG_IDX) && i_flags_we)
               regs_next[i][FLAG_HW_BITS-1:0] = i_flags;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         o_collide <= 1'b0;
         o_err     <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_next[i];
         o_collide           <= collide_now;
         o_err[ERR_COLLIDE]  <= (o_err[ERR_COLLIDE]  && !i_err_clr) || collide_now;
         o_err[ERR_RSV_BUSY] <= (o_err[ERR_RSV_BUSY] && !i_err_clr) || rsv_busy;
      end
   end

`ifdef ARGON_REGFILE_BYPASS_EN
   // Next-state view already carries A-over-B priority, the flags merge and a zero r0.
   assign rd_src = regs_next;
`else
   assign rd_src = regs;
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign o_rd_data[k*DATA_W +: DATA_W] = rd_src[i_rd_addr[k*IDX_W +: IDX_W]];
   end

   assign o_flags = rd_src[FLAG_IDX];

   argon_regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_scoreboard (
      .clk      (i_Clk),
      .rst      (i_Reset),
      .rsv_en   (i_rsv_en),
      .rsv_addr (i_rsv_addr),
      .clr_mask (clr_mask),
      .busy     (o_busy),
      .rsv_busy (rsv_busy)
   );

endmodule

// File: tb/tb_argon_regfile_mp.sv
// Bench for argon_regfile_mp (DATA_W=16, NUM_REGS=8, NUM_RD=2): table-driven vectors
// with an expected-result queue, plus hand sequences for async reset and bypass.
module tb_argon_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic        wa_en, wb_en, flags_we, rsv_en, err_clr;
   logic [2:0]  wa_addr, wb_addr, rsv_addr;
   logic [15:0] wa_data, wb_data, flags_out;
   logic [7:0]  flags_in, busy;
   logic        collide;
   logic [1:0]  err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   argon_regfile_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2)) dut (
      .i_Clk(clk), .i_Reset(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
      .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_flags_we(flags_we), .i_flags(flags_in), .o_flags(flags_out),
      .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_busy(busy),
      .o_collide(collide), .o_err(err), .i_err_clr(err_clr)
   );

   typedef struct {
      logic        wa_en; logic [2:0] wa_addr; logic [15:0] wa_data;
      logic        wb_en; logic [2:0] wb_addr; logic [15:0] wb_data;
      logic        fwe;   logic [7:0] flags;
      logic        rsv_en; logic [2:0] rsv_addr; logic clr;
      logic [2:0]  ra0, ra1;
      logic [15:0] e_rd0, e_rd1, e_flags; logic [7:0] e_busy; logic e_col; logic [1:0] e_err;
   } vec_t;

   typedef struct {
      logic [15:0] rd0, rd1, flags; logic [7:0] busy; logic col; logic [1:0] err;
   } exp_t;

   vec_t vecs [17];
   exp_t exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_strobes();
      wa_en = 1'b0; wb_en = 1'b0; flags_we = 1'b0; rsv_en = 1'b0; err_clr = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      exp_t e;
      @(negedge clk);
      wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
      wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
      flags_we = v.fwe; flags_in = v.flags;
      rsv_en = v.rsv_en; rsv_addr = v.rsv_addr; err_clr = v.clr;
      rd_addr = {v.ra1, v.ra0};
      e = '{v.e_rd0, v.e_rd1, v.e_flags, v.e_busy, v.e_col, v.e_err};
      exp_q.push_back(e);
      @(posedge clk);
      #1 idle_strobes();
      #1;
   endtask

   task automatic compare_vec(input int idx);
      exp_t e;
      if (exp_q.size() == 0) begin
         check($sformatf("v%0d_queue_empty", idx), 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check($sformatf("v%0d_rd0", idx),   {16'h0, rd_data[15:0]},  {16'h0, e.rd0});
      check($sformatf("v%0d_rd1", idx),   {16'h0, rd_data[31:16]}, {16'h0, e.rd1});
      check($sformatf("v%0d_flags", idx), {16'h0, flags_out},      {16'h0, e.flags});
      check($sformatf("v%0d_busy", idx),  {24'h0, busy},           {24'h0, e.busy});
      check($sformatf("v%0d_collide", idx), {31'h0, collide},      {31'h0, e.col});
      check($sformatf("v%0d_err", idx),   {30'h0, err},            {30'h0, e.err});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //          waE wa    waData    wbE wb    wbData    fwe flg    rsv ra   clr  a0    a1    rd0       rd1       flags     busy   col   err
      vecs[0]  = '{1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 3'd0, 0, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000, 8'h00, 1'b0, 2'b00};
      vecs[1]  = '{1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 3'd0, 0, 3'd0, 3'd3, 16'h0000, 16'h1234, 16'h0000, 8'h00, 1'b0, 2'b00};
      vecs[2]  = '{1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555, 0, 8'h00, 0, 3'd0, 0, 3'd5, 3'd3, 16'hAAAA, 16'h1234, 16'h0000, 8'h00, 1'b1, 2'b01};
      vecs[3]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 3'd0, 0, 3'd5, 3'd0, 16'hAAAA, 16'h0000, 16'h0000, 8'h00, 1'b0, 2'b01};
      vecs[4]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 0, 3'd0, 1, 3'd5, 3'd0, 16'hAAAA, 16'h0000, 16'h0000, 8'h00, 1'b0, 2'b00};
      vecs[5]  = '{1, 3'd7, 16'hFF00, 0, 3'd0, 16'h0000, 1, 8'h3C, 0, 3'd0, 0, 3'd7, 3'd5, 16'hFF3C, 16'hAAAA, 16'hFF3C, 8'h00, 1'b0, 2'b00};
      vecs[6]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 8'h01, 0, 3'd0, 0, 3'd7, 3'd0, 16'hFF01, 16'h0000, 16'hFF01, 8'h00, 1'b0, 2'b00};
      vecs[7]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 3'd2, 0, 3'd2, 3'd0, 16'h0000, 16'h0000, 16'hFF01, 8'h04, 1'b0, 2'b00};
      vecs[8]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 3'd2, 0, 3'd2, 3'd0, 16'h0000, 16'h0000, 16'hFF01, 8'h04, 1'b0, 2'b10};
      vecs[9]  = '{0, 3'd0, 16'h0000, 1, 3'd2, 16'h2222, 0, 8'h00, 1, 3'd4, 0, 3'd2, 3'd0, 16'h2222, 16'h0000, 16'hFF01, 8'h10, 1'b0, 2'b10};
      vecs[10] = '{1, 3'd6, 16'h6666, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 3'd6, 0, 3'd6, 3'd2, 16'h6666, 16'h2222, 16'hFF01, 8'h50, 1'b0, 2'b10};
      vecs[11] = '{1, 3'd4, 16'h4444, 1, 3'd1, 16'h1111, 0, 8'h00, 0, 3'd0, 0, 3'd1, 3'd4, 16'h1111, 16'h4444, 16'hFF01, 8'h40, 1'b0, 2'b10};
      vecs[12] = '{0, 3'd0, 16'h0000, 1, 3'd0, 16'hBBBB, 0, 8'h00, 1, 3'd0, 0, 3'd0, 3'd1, 16'h0000, 16'h1111, 16'hFF01, 8'h40, 1'b0, 2'b10};
      vecs[13] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 8'h00, 1, 3'd6, 1, 3'd6, 3'd4, 16'h6666, 16'h4444, 16'hFF01, 8'h40, 1'b0, 2'b10};
      vecs[14] = '{1, 3'd3, 16'h0BAD, 1, 3'd3, 16'hDEAD, 0, 8'h00, 0, 3'd0, 1, 3'd3, 3'd6, 16'h0BAD, 16'h6666, 16'hFF01, 8'h40, 1'b1, 2'b01};
      vecs[15] = '{0, 3'd0, 16'h0000, 1, 3'd7, 16'h1234, 1, 8'h77, 0, 3'd0, 0, 3'd7, 3'd3, 16'h1277, 16'h0BAD, 16'h1277, 8'h40, 1'b0, 2'b01};
      vecs[16] = '{1, 3'd0, 16'h1111, 1, 3'd0, 16'h2222, 0, 8'h00, 0, 3'd0, 0, 3'd0, 3'd7, 16'h0000, 16'h1277, 16'h1277, 8'h40, 1'b0, 2'b01};

      // clock/reset
      idle_strobes();
      wa_addr = '0; wa_data = '0; wb_addr = '0; wb_data = '0;
      flags_in = '0; rsv_addr = '0; rd_addr = {3'd3, 3'd7};
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd0", {16'h0, rd_data[15:0]}, 32'h0);
      check("reset_busy", {24'h0, busy}, 32'h0);
      check("reset_err", {30'h0, err}, 32'h0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         apply_vec(vecs[i]);
         compare_vec(i);
      end

      // collision then asynchronous reset mid-cycle, with writes and a reservation in flight
      @(negedge clk);
      wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'h1357;
      wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h2468;
      @(posedge clk);
      #1 idle_strobes();
      check("pre_reset_collide", {31'h0, collide}, 32'h1);
      @(negedge clk);
      wa_en = 1'b1; wa_addr = 3'd6; wa_data = 16'h9999;
      rsv_en = 1'b1; rsv_addr = 3'd3;
      rd_addr = {3'd7, 3'd6};
      #2 rst = 1'b1;
      #1;
      check("async_rst_rd_r6", {16'h0, rd_data[15:0]}, 32'h0);
      check("async_rst_rd_r7", {16'h0, rd_data[31:16]}, 32'h0);
      check("async_rst_flags", {16'h0, flags_out}, 32'h0);
      check("async_rst_busy", {24'h0, busy}, 32'h0);
      check("async_rst_err", {30'h0, err}, 32'h0);
      check("async_rst_collide", {31'h0, collide}, 32'h0);
      @(posedge clk);
      #1 idle_strobes();
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_r6_dropped", {16'h0, rd_data[15:0]}, 32'h0);
      check("post_rst_busy_dropped", {24'h0, busy}, 32'h0);

      // same-cycle read of a register being written
      @(negedge clk);
      wa_en = 1'b1; wa_addr = 3'd1; wa_data = 16'hBEEF;
      rd_addr = {3'd0, 3'd1};
      #1;
`ifdef ARGON_REGFILE_BYPASS_EN
      check("bypass_same_cycle", {16'h0, rd_data[15:0]}, 32'h0000BEEF);
`else
      check("no_bypass_same_cycle", {16'h0, rd_data[15:0]}, 32'h00000000);
`endif
      check("bypass_r0_port1", {16'h0, rd_data[31:16]}, 32'h0);
      @(posedge clk);
      #1 idle_strobes();
      #1 check("write_visible_next", {16'h0, rd_data[15:0]}, 32'h0000BEEF);

      check("exp_q_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
